// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// spi_pkg : shared types and helpers for the SPI controller/peripheral pair
// Rev 1.0
// ============================================================================
package spi_pkg;

  localparam int DATA_WIDTH_DEFAULT = 8;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  localparam logic [0:0] ST_IDLE   = IDLE;
  localparam logic [0:0] ST_ACTIVE = ACTIVE;

  typedef struct packed {
    logic pol;
    logic pha;
  } spi_mode_t;

  // Leading edge: sck leaves its idle level.
  function automatic logic is_leading(input logic prev, input logic cur, input logic pol);
    return (prev == pol) && (cur != pol);
  endfunction

  // Valid only when an sck edge is present.
  function automatic logic is_sample(input spi_mode_t mode, input logic leading);
    return leading ^ mode.pha;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_peripheral_if.sv
`default_nettype none
// ============================================================================
// spi_peripheral_if : SPI pins plus tx/rx register-adapter handshake
// Rev 1.0
// ============================================================================
interface spi_peripheral_if
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) ();

  logic                  sck;
  logic                  cs_n;
  logic                  mosi;
  logic                  miso;
  logic                  miso_oe;
  logic                  pol;
  logic                  pha;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  tx_underrun;
  logic                  busy;

  modport slave (
    input  sck, cs_n, mosi, pol, pha, tx_data, tx_valid,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );

  modport master (
    output sck, cs_n, mosi, pol, pha, tx_data, tx_valid,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );

endinterface
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// spi_sync_edge : multi-flop synchronizer with rise/fall detection
// Rev 1.0
// ============================================================================
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  wire logic clk,
  input  wire logic async_in,
  output logic      sync_out,
  output logic      rise,
  output logic      fall
);

  // No reset on the chain: it must keep tracking the pin through a reset so
  // that a chip select already low when reset lifts is not mistaken for a fall.
  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  generate
    if (SYNC_STAGES > 1) begin : g_chain
      always_ff @(posedge clk) begin
        chain <= {chain[SYNC_STAGES-2:0], async_in};
      end
    end else begin : g_single
      always_ff @(posedge clk) begin
        chain <= async_in;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    prev <= chain[SYNC_STAGES-1];
  end

  assign sync_out = chain[SYNC_STAGES-1];
  assign rise     = sync_out & ~prev;
  assign fall     = ~sync_out & prev;

endmodule
`default_nettype wire

// File: rtl/spi_peripheral.sv
`default_nettype none
// ============================================================================
// spi_peripheral : oversampled SPI target, all four pol/pha modes
// Rev 1.0
// ============================================================================
module spi_peripheral
  import spi_pkg::*;
#(
  parameter int                    DATA_WIDTH  = DATA_WIDTH_DEFAULT,
  parameter logic [DATA_WIDTH-1:0] TX_DEFAULT  = '0,
  parameter int                    SYNC_STAGES = 2
) (
  input  wire logic        clk,
  input  wire logic        rst,
  spi_peripheral_if.slave  bus
);

  localparam int                CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic sck_sync, sck_rise, sck_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic mosi_sync;
  logic [SYNC_STAGES-1:0] mosi_chain;

  logic [0:0]            state;
  spi_mode_t             mode;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-2:0] rx_shift;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  first_edge;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_full;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  tx_underrun;

  logic                  sck_edge, sck_prev, lead;
  logic                  sample_edge, shift_edge;
  logic                  load_req;
  logic [DATA_WIDTH-1:0] load_val;
  logic [DATA_WIDTH-1:0] rx_next;
  logic                  is_active;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
    .clk      (clk),
    .async_in (bus.sck),
    .sync_out (sck_sync),
    .rise     (sck_rise),
    .fall     (sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .clk      (clk),
    .async_in (bus.cs_n),
    .sync_out (cs_sync),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  // mosi shares the sck latency so the sampled bit lines up with its edge
  generate
    if (SYNC_STAGES > 1) begin : g_mosi_chain
      always_ff @(posedge clk) begin
        mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], bus.mosi};
      end
    end else begin : g_mosi_single
      always_ff @(posedge clk) begin
        mosi_chain <= bus.mosi;
      end
    end
  endgenerate

  assign mosi_sync = mosi_chain[SYNC_STAGES-1];

  assign is_active   = (state == ST_ACTIVE);
  assign sck_edge    = sck_rise | sck_fall;
  assign sck_prev    = sck_sync ^ sck_edge;
  assign lead        = sck_edge & is_leading(sck_prev, sck_sync, mode.pol);
  assign sample_edge = sck_edge & is_sample(mode, lead);
  assign shift_edge  = sck_edge & ~is_sample(mode, lead);
  assign rx_next     = {rx_shift, mosi_sync};

  // A shift edge with no bits pending starts a new byte (never the very first
  // leading edge of a pha=1 frame, whose MSB was already presented at cs_n fall).
  assign load_req = (!is_active && cs_fall)
                  | (is_active && !cs_rise && shift_edge && !first_edge && (bit_cnt == '0));
  assign load_val = hold_full ? hold_data : TX_DEFAULT;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_data <= '0;
      hold_full <= 1'b0;
    end else if (load_req && hold_full) begin
      hold_full <= 1'b0;
    end else if (bus.tx_valid && !hold_full) begin
      hold_data <= bus.tx_data;
      hold_full <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      mode        <= '0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      bit_cnt     <= '0;
      first_edge  <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= load_req & ~hold_full;
      if (load_req) begin
        tx_shift <= load_val;
      end
      case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            mode       <= '{pol: bus.pol, pha: bus.pha};
            bit_cnt    <= '0;
            first_edge <= 1'b1;
            state      <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (cs_rise) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
          end else begin
            if (sck_edge) begin
              first_edge <= 1'b0;
            end
            if (sample_edge) begin
              rx_shift <= rx_next[DATA_WIDTH-2:0];
              if (bit_cnt == LAST_BIT) begin
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
                bit_cnt  <= '0;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
            if (shift_edge && !first_edge && (bit_cnt != '0)) begin
              tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output enable follows the synchronized chip select directly, one cycle
  // ahead of the state register.
  assign bus.miso_oe     = ~cs_sync & (is_active | (cs_fall & ~rst));
  assign bus.busy        = bus.miso_oe;
  assign bus.miso        = is_active & tx_shift[DATA_WIDTH-1];
  assign bus.tx_ready    = ~hold_full;
  assign bus.rx_data     = rx_data;
  assign bus.rx_valid    = rx_valid;
  assign bus.tx_underrun = tx_underrun;

endmodule
`default_nettype wire

// File: tb/tb_spi_peripheral.sv
`default_nettype none
// Bench acts as the SPI controller; a compare process checks rx strobes,
// their latency and the output-enable window against a high-level model.
`timescale 1ns/1ps
module tb_spi_peripheral;
  import spi_pkg::*;

  localparam int DW   = 8;
  localparam int SYNC = 2;
  localparam int H    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_peripheral_if #(.DATA_WIDTH(DW)) bus ();

  spi_peripheral #(.DATA_WIDTH(DW), .TX_DEFAULT(8'h00), .SYNC_STAGES(SYNC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] data;
    int         due;
  } rx_exp_t;

  rx_exp_t rx_q[$];
  rx_exp_t e;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int und_cnt = 0;
  int rxv_cnt = 0;
  logic cs_p = 1'b1;
  logic armed = 1'b0;
  logic exp_oe;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Model: enable is the chip select delayed by the synchronizer, but only once
  // cs_n has been seen high since the last reset.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) armed = 1'b0;
    else if (cs_p) armed = 1'b1;
    exp_oe = !cs_p && armed;
    cs_p = bus.cs_n;
    if (cyc > 4) begin
      check("miso_oe", bus.miso_oe, exp_oe);
      check("busy", bus.busy, exp_oe);
    end
    if (bus.tx_underrun) und_cnt++;
    if (bus.rx_valid) begin
      rxv_cnt++;
      if (rx_q.size() == 0) begin
        check("rx_unexpected", bus.rx_valid, 0);
      end else begin
        e = rx_q.pop_front();
        check("rx_data", bus.rx_data, e.data);
        check("rx_latency", cyc, e.due);
      end
    end else if (rx_q.size() != 0 && cyc > rx_q[0].due) begin
      check("rx_missing", bus.rx_valid, 1);
      void'(rx_q.pop_front());
    end
  end

  task automatic set_mode(input logic p, input logic h);
    @(negedge clk);
    bus.pol = p;
    bus.pha = h;
    bus.sck = p;
    repeat (2*H) @(negedge clk);
  endtask

  task automatic write_tx(input logic [7:0] b);
    int n = 0;
    while (!bus.tx_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.tx_ready) check("tx_ready_timeout", bus.tx_ready, 1);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic cs_low(input bit chk);
    @(negedge clk);
    bus.cs_n = 1'b0;
    if (chk) begin
      @(negedge clk);
      check("oe_fall_d1", bus.miso_oe, 0);
      @(negedge clk);
      check("oe_fall_d2", bus.miso_oe, 1);
      repeat (H-2) @(negedge clk);
    end else begin
      repeat (H) @(negedge clk);
    end
  endtask

  task automatic cs_high(input bit chk);
    repeat (H) @(negedge clk);
    bus.cs_n = 1'b1;
    if (chk) begin
      @(negedge clk);
      check("oe_rise_d1", bus.miso_oe, 1);
      @(negedge clk);
      check("oe_rise_d2", bus.miso_oe, 0);
      repeat (2*H-2) @(negedge clk);
    end else begin
      repeat (2*H) @(negedge clk);
    end
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_q.push_back('{data: b, due: cyc + SYNC + 1});
  endtask

  // Shifts n bits of b (MSB first) and returns what miso carried.
  task automatic xfer(input logic [7:0] b, input int n, input bit exp_rx, output logic [7:0] m);
    m = 8'h00;
    for (int i = 7; i >= 8 - n; i--) begin
      if (!bus.pha) begin
        bus.mosi = b[i];
        repeat (H) @(negedge clk);
        m[i] = bus.miso;
        bus.sck = ~bus.pol;
        if (i == 0 && exp_rx) push_rx(b);
        repeat (H) @(negedge clk);
        bus.sck = bus.pol;
      end else begin
        bus.sck  = ~bus.pol;
        bus.mosi = b[i];
        repeat (H) @(negedge clk);
        m[i] = bus.miso;
        bus.sck = bus.pol;
        if (i == 0 && exp_rx) push_rx(b);
        repeat (H) @(negedge clk);
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_miso"}, bus.miso, 0);
    check({tag, "_miso_oe"}, bus.miso_oe, 0);
    check({tag, "_tx_ready"}, bus.tx_ready, 1);
    check({tag, "_rx_data"}, bus.rx_data, 0);
    check({tag, "_rx_valid"}, bus.rx_valid, 0);
    check({tag, "_tx_underrun"}, bus.tx_underrun, 0);
    check({tag, "_busy"}, bus.busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] m, m0, m1, m2;
    logic [1:0] md2;
    int u0, r0;
    int und_exp[3] = '{0, 1, 0};

    bus.sck = 1'b0; bus.cs_n = 1'b1; bus.mosi = 1'b0;
    bus.pol = 1'b0; bus.pha = 1'b0;
    bus.tx_data = 8'h00; bus.tx_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");

    // Mode 0 with a preloaded byte; final trailing edge reloads and underruns.
    set_mode(1'b0, 1'b0);
    u0 = und_cnt; r0 = rxv_cnt;
    write_tx(8'hA5);
    check("t1_tx_ready_full", bus.tx_ready, 0);
    cs_low(1'b0);
    check("t1_tx_ready_after_load", bus.tx_ready, 1);
    xfer(8'h3C, 8, 1'b1, m);
    check("t1_miso_byte", m, 8'hA5);
    cs_high(1'b0);
    check("t1_rx_data", bus.rx_data, 8'h3C);
    check("t1_rx_pulses", rxv_cnt - r0, 1);
    check("t1_underruns", und_cnt - u0, 1);

    // Modes 1..3; only pha=0 reloads after the last bit.
    for (int md = 1; md < 4; md++) begin
      md2 = 2'(md);
      set_mode(md2[1], md2[0]);
      u0 = und_cnt;
      write_tx(8'h81);
      cs_low(1'b1);
      xfer(8'h7E, 8, 1'b1, m);
      check("t2_miso_byte", m, 8'h81);
      cs_high(1'b1);
      check("t2_rx_data", bus.rx_data, 8'h7E);
      check("t2_underruns", und_cnt - u0, und_exp[md-1]);
    end

    // Underrun: nothing written, mode 1.
    set_mode(1'b0, 1'b1);
    u0 = und_cnt;
    cs_low(1'b0);
    xfer(8'h55, 8, 1'b1, m);
    check("t3_miso_byte", m, 8'h00);
    cs_high(1'b0);
    check("t3_underruns", und_cnt - u0, 1);
    check("t3_rx_data", bus.rx_data, 8'h55);

    // Three back-to-back bytes, mode 0, writer refills as tx_ready allows.
    set_mode(1'b0, 1'b0);
    u0 = und_cnt; r0 = rxv_cnt;
    write_tx(8'h11);
    cs_low(1'b0);
    fork
      begin
        xfer(8'hF0, 8, 1'b1, m0);
        xfer(8'h0F, 8, 1'b1, m1);
        xfer(8'hAA, 8, 1'b1, m2);
      end
      begin
        write_tx(8'h22);
        write_tx(8'h33);
      end
    join
    cs_high(1'b0);
    check("t4_miso0", m0, 8'h11);
    check("t4_miso1", m1, 8'h22);
    check("t4_miso2", m2, 8'h33);
    check("t4_rx_pulses", rxv_cnt - r0, 3);
    check("t4_underruns", und_cnt - u0, 1);

    // Partial byte discarded, then a full frame.
    u0 = und_cnt; r0 = rxv_cnt;
    cs_low(1'b0);
    xfer(8'hFF, 5, 1'b0, m);
    cs_high(1'b0);
    check("t5_partial_no_rx", rxv_cnt - r0, 0);
    cs_low(1'b0);
    xfer(8'hC3, 8, 1'b1, m);
    cs_high(1'b0);
    check("t5_rx_data", bus.rx_data, 8'hC3);
    check("t5_miso_byte", m, 8'h00);
    check("t5_underruns", und_cnt - u0, 3);

    // Reset mid-byte with cs_n held low; the rest of that window is ignored.
    u0 = und_cnt; r0 = rxv_cnt;
    cs_low(1'b0);
    xfer(8'h5A, 4, 1'b0, m);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("midrst");
    xfer(8'hFF, 8, 1'b0, m);
    check("t6_no_rx_while_low", rxv_cnt - r0, 0);
    check("t6_oe_still_low", bus.miso_oe, 0);
    cs_high(1'b0);
    cs_low(1'b0);
    xfer(8'h96, 8, 1'b1, m);
    cs_high(1'b0);
    check("t6_rx_data", bus.rx_data, 8'h96);
    check("t6_rx_pulses", rxv_cnt - r0, 1);
    check("t6_underruns", und_cnt - u0, 3);

    repeat (10) @(negedge clk);
    check("rx_queue_drained", rx_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_peripheral.md
Name: spi_peripheral

Overview:
- SPI target: the far-end counterpart of the team's SPI controller.
- Receives an MSB-first byte on mosi and returns a byte on miso in the same frame. Supports all four pol/pha modes.
- Every SPI pin is oversampled in the clk domain; no logic is clocked by sck.
- Sits behind a register/bus adapter: tx holding-register handshake on one side, one-cycle rx_valid strobe on the other.

Parameters:
- DATA_WIDTH, 8: bits per transfer.
- TX_DEFAULT, 8'h00: value shifted out when no tx data is held (underrun).
- SYNC_STAGES, 2: synchronizer depth on sck, cs_n and mosi.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sck  in  1  SPI clock from controller (asynchronous).
- cs_n  in  1  chip select, active low (asynchronous).
- mosi  in  1  serial data in.
- miso  out  1  serial data out (MSB of tx shift register).
- miso_oe  out  1  output enable; high while the synchronized cs_n is low.
- pol  in  1  sck idle level.
- pha  in  1  0: sample on leading edge; 1: sample on trailing edge.
- tx_data  in  DATA_WIDTH  byte for the next transfer.
- tx_valid  in  1  tx_data offered.
- tx_ready  out  1  tx holding register empty.
- rx_data  out  DATA_WIDTH  last completed received byte.
- rx_valid  out  1  one-cycle strobe, rx_data updated.
- tx_underrun  out  1  one-cycle strobe, TX_DEFAULT loaded.
- busy  out  1  frame active (synchronized cs_n low).

Behaviour:
- Reset values:
  - miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, busy=0.
  - Shift registers and bit_cnt = 0; state = IDLE; latched mode = {0,0}.
  - A reset mid-frame aborts the frame. The block stays IDLE until cs_n is seen high, then low again.
- Synchronization and edge detection:
  - sck, cs_n and mosi pass through SYNC_STAGES flops.
  - Edges are detected by comparing against the previous synchronized value.
  - Timing rule: sck high and low times must each be ≥ 3 clk.
  - rx_valid rises exactly SYNC_STAGES+1 clk after the final sample edge reaches the pin.
- Mode terms:
  - Leading edge = sck leaving pol; trailing edge = sck returning to pol.
  - Sample edge = leading if pha=0, trailing if pha=1. Shift edge = the other edge.
- Holding register:
  - tx_valid & tx_ready writes tx_data into the holding register; tx_ready then drops to 0.
  - A load from the holding register sets tx_ready back to 1.
  - There is no bypass: data accepted in the same cycle as a load goes to the next byte.
- State IDLE:
  - miso_oe=0 and miso=0.
  - On the cs_n falling edge (synchronized):
    - latch pol/pha;
    - load tx_shift from the holding register if full, else from TX_DEFAULT and pulse tx_underrun;
    - clear bit_cnt;
    - set first_edge=1;
    - go to ACTIVE.
  - pol/pha changes while ACTIVE are ignored.
- State ACTIVE:
  - Sample edge: rx_shift <= {rx_shift[DW-2:0], mosi_sync}; bit_cnt++.
  - When bit_cnt reaches DATA_WIDTH: rx_data <= assembled byte; pulse rx_valid; bit_cnt <= 0.
  - rx_valid has no backpressure. An unread rx_data is simply overwritten.
  - Shift edge, pha=0: shift tx_shift left, except on the trailing edge that follows a byte's final sample; that edge reloads (holding register or TX_DEFAULT+underrun).
  - Shift edge, pha=1, first leading edge of the frame (first_edge=1): no shift; clear first_edge.
  - Shift edge, pha=1, later leading edge with bit_cnt=0: reload.
  - Shift edge, pha=1, any other leading edge: shift left.
  - cs_n rising edge: go to IDLE. A partial byte is discarded: no rx_valid, bit_cnt cleared, holding register untouched.
  - An sck edge in the same cycle as the cs_n rising edge is ignored.
- Back-to-back bytes within one cs_n window are supported indefinitely.

Decomposition:
- spi_pkg holds:
  - the state enum (IDLE, ACTIVE);
  - the spi_mode_t struct {pol, pha};
  - DATA_WIDTH_DEFAULT;
  - helper functions is_leading(prev, cur, pol) and is_sample(mode, leading).
- The controller uses the same package.
- Sub-module spi_sync_edge:
  - generic SYNC_STAGES synchronizer with rise/fall outputs;
  - instantiated for sck and cs_n;
  - mosi uses the synchronizer only.

Test Plan:
- Mode 0, tx_data=8'hA5 loaded before the frame; controller sends 8'h3C.
  - Required: rx_data=8'h3C with a single rx_valid.
  - Required: controller receives 8'hA5.
  - Required: tx_ready returns to 1 at the cs_n fall.
- Modes 1, 2 and 3, each with tx=8'h81 and mosi=8'h7E.
  - Required: both bytes are exchanged correctly in all three modes.
  - Required: miso_oe follows cs_n with a 2-clk delay.
- No tx_valid before the frame; controller sends 8'h55.
  - Required: tx_underrun pulses once and the controller receives 8'h00.
  - Required: rx_data=8'h55.
- Three back-to-back bytes in one frame, with tx 8'h11, 8'h22, 8'h33 written as tx_ready allows; mosi 8'hF0, 8'h0F, 8'hAA.
  - Required: three rx_valid pulses carrying those mosi values.
  - Required: miso carries 8'h11, 8'h22, 8'h33.
- cs_n deasserted after 5 bits, then a full new frame with mosi=8'hC3.
  - Required: no rx_valid for the partial byte.
  - Required: the next frame yields rx_data=8'hC3.
- rst asserted mid-byte while cs_n is held low, then released.
  - Required: all outputs return to reset values.
  - Required: no rx_valid until cs_n cycles high then low and a full byte is received.
